// File: rtl/tm_pkg.sv
// Shared types and default sizing for the Turing machine input sequencer and core.
package tm_pkg;

  localparam int TM_DW        = 4;
  localparam int TM_MAX_WORDS = 64;
  localparam int TM_HOLD      = 2;
  localparam int TM_MAX_STEPS = 1023;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_HI,
    LOAD_LO,
    DONE,
    WAIT_STEP,
    STEP_HI,
    STEP_LO,
    FINISHED
  } seq_state_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/tm_input_sequencer_if.sv
// Stream, compute-control and status signals between the sequencer and its neighbours.
interface tm_input_sequencer_if
  import tm_pkg::*;
#(
  parameter int DW        = TM_DW,
  parameter int MAX_WORDS = TM_MAX_WORDS
);
  localparam int WCW = $clog2(MAX_WORDS + 1);

  logic           in_valid;
  logic [DW-1:0]  in_data;
  logic           in_last;
  logic           in_ready;
  logic           run;
  logic           step;
  logic           Compute_done;
  logic [DW-1:0]  input_data;
  logic           Next;
  logic           Done;
  logic           busy;
  logic           finished;
  logic           overflow;
  logic           timeout;
  logic [WCW-1:0] word_count;
  logic [15:0]    step_count;

  modport master (
    output in_valid, in_data, in_last, run, step, Compute_done,
    input  in_ready, input_data, Next, Done, busy, finished, overflow, timeout,
           word_count, step_count
  );

  modport slave (
    input  in_valid, in_data, in_last, run, step, Compute_done,
    output in_ready, input_data, Next, Done, busy, finished, overflow, timeout,
           word_count, step_count
  );

endinterface

// File: rtl/phase_timer.sv
// Down-counter timing each Next high/low phase; expire_o marks the last cycle of a phase.
module phase_timer #(
  parameter int HOLD = 2
) (
  input  logic clock,
  input  logic reset_n,
  input  logic load_i,
  output logic expire_o
);
  localparam logic [3:0] LOAD_VAL = 4'(HOLD - 1);

  logic [3:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = LOAD_VAL;
    end else if (cnt_q != 4'd0) begin
      cnt_d = cnt_q - 4'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      cnt_q <= 4'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire_o = (cnt_q == 4'd0);

endmodule

// File: rtl/tm_input_sequencer.sv
// Converts a word stream into the core's Next/Done level handshake, then paces compute steps.
// Optional step limit: define TM_SEQ_STEP_LIMIT_EN.
module tm_input_sequencer
  import tm_pkg::*;
#(
  parameter int DW        = TM_DW,
  parameter int MAX_WORDS = TM_MAX_WORDS,
  parameter int HOLD      = TM_HOLD,
  parameter int MAX_STEPS = TM_MAX_STEPS
) (
  input logic                 clock,
  input logic                 reset_n,
  tm_input_sequencer_if.slave bus
);
  localparam int             WCW    = $clog2(MAX_WORDS + 1);
  localparam logic [WCW-1:0] WC_MAX = WCW'(MAX_WORDS);

  if (HOLD < 1 || HOLD > 15 || MAX_STEPS < 1) begin : g_bad_param
    $error("tm_input_sequencer: HOLD must be 1..15 and MAX_STEPS at least 1");
  end

  seq_state_t     state_q, state_d;
  logic [WCW-1:0] word_count_q, word_count_d;
  logic [15:0]    step_count_q, step_count_d;
  logic [DW-1:0]  input_data_q, input_data_d;
  logic           last_q, last_d;
  logic           overflow_q, overflow_d;
  logic           next_q, next_d;
  logic           done_q, done_d;
  logic           busy_q, busy_d;
  logic           finished_q, finished_d;
  logic           in_ready_q, in_ready_d;
  logic           timer_load;
  logic           expire;

`ifdef TM_SEQ_STEP_LIMIT_EN
  localparam logic [15:0] STEP_LIMIT = 16'(MAX_STEPS);
  logic timeout_q, timeout_d;
`endif

  phase_timer #(.HOLD(HOLD)) u_timer (
    .clock    (clock),
    .reset_n  (reset_n),
    .load_i   (timer_load),
    .expire_o (expire)
  );

  always_comb begin
    state_d      = state_q;
    word_count_d = word_count_q;
    step_count_d = step_count_q;
    input_data_d = input_data_q;
    last_d       = last_q;
    overflow_d   = overflow_q;
`ifdef TM_SEQ_STEP_LIMIT_EN
    timeout_d    = timeout_q;
`endif

    case (state_q)
      IDLE: begin
        // in_ready_q is low for one cycle after reset release, so gate on it
        if (bus.in_valid && in_ready_q) begin
          if (word_count_q < WC_MAX) begin
            input_data_d = bus.in_data;
            word_count_d = word_count_q + WCW'(1);
            last_d       = bus.in_last;
            state_d      = LOAD_HI;
          end else begin
            overflow_d = 1'b1;
            if (bus.in_last) begin
              state_d = DONE;
            end
          end
        end
      end
      LOAD_HI: if (expire) state_d = LOAD_LO;
      LOAD_LO: if (expire) state_d = last_q ? DONE : IDLE;
      DONE:    state_d = WAIT_STEP;
      WAIT_STEP: begin
        if (bus.Compute_done) begin
          state_d = FINISHED;
`ifdef TM_SEQ_STEP_LIMIT_EN
        end else if (step_count_q == STEP_LIMIT) begin
          state_d   = FINISHED;
          timeout_d = 1'b1;
`endif
        end else if (bus.run || bus.step) begin
          state_d = STEP_HI;
        end
      end
      STEP_HI: if (expire) state_d = STEP_LO;
      STEP_LO: begin
        if (expire) begin
          step_count_d = sat_inc16(step_count_q);
          state_d      = WAIT_STEP;
        end
      end
      FINISHED: state_d = FINISHED;
      default:  state_d = IDLE;
    endcase

    // Every state change enters a fresh phase; the timer is ignored outside HI/LO states
    timer_load = (state_d != state_q);

    next_d     = (state_d == LOAD_HI) || (state_d == STEP_HI);
    done_d     = (state_d == DONE);
    busy_d     = (state_d != IDLE) && (state_d != FINISHED);
    finished_d = (state_d == FINISHED);
    in_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      word_count_q <= '0;
      step_count_q <= '0;
      input_data_q <= '0;
      last_q       <= 1'b0;
      overflow_q   <= 1'b0;
      next_q       <= 1'b0;
      done_q       <= 1'b0;
      busy_q       <= 1'b0;
      finished_q   <= 1'b0;
      in_ready_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      word_count_q <= word_count_d;
      step_count_q <= step_count_d;
      input_data_q <= input_data_d;
      last_q       <= last_d;
      overflow_q   <= overflow_d;
      next_q       <= next_d;
      done_q       <= done_d;
      busy_q       <= busy_d;
      finished_q   <= finished_d;
      in_ready_q   <= in_ready_d;
    end
  end

`ifdef TM_SEQ_STEP_LIMIT_EN
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= timeout_d;
    end
  end

  assign bus.timeout = timeout_q;
`else
  assign bus.timeout = 1'b0;
`endif

  assign bus.in_ready   = in_ready_q;
  assign bus.input_data = input_data_q;
  assign bus.Next       = next_q;
  assign bus.Done       = done_q;
  assign bus.busy       = busy_q;
  assign bus.finished   = finished_q;
  assign bus.overflow   = overflow_q;
  assign bus.word_count = word_count_q;
  assign bus.step_count = step_count_q;

endmodule

// File: tb/tb_tm_input_sequencer.sv
// Randomized bench for tm_input_sequencer: records Next/Done/input_data per cycle and
// checks pulse structure and final counters against a transaction-level model.
module tb_tm_input_sequencer;
  import tm_pkg::*;

  localparam int DW        = 4;
  localparam int MAX_WORDS = 4;
  localparam int HOLD      = 2;
  localparam int MAX_STEPS = 8;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  tm_input_sequencer_if #(.DW(DW), .MAX_WORDS(MAX_WORDS)) bus ();

  tm_input_sequencer #(
    .DW(DW), .MAX_WORDS(MAX_WORDS), .HOLD(HOLD), .MAX_STEPS(MAX_STEPS)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  logic          tr_next[$];
  logic          tr_done[$];
  logic [DW-1:0] tr_data[$];
  logic [DW-1:0] words_q[$];
  bit            rec_en = 1'b0;

  always @(posedge clock) begin
    #1;
    if (rec_en) begin
      tr_next.push_back(bus.Next);
      tr_done.push_back(bus.Done);
      tr_data.push_back(bus.input_data);
    end
  end

  task automatic do_reset();
    bus.in_valid     = 1'b0;
    bus.in_data      = '0;
    bus.in_last      = 1'b0;
    bus.run          = 1'b0;
    bus.step         = 1'b0;
    bus.Compute_done = 1'b0;
    reset_n = 1'b0;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
  endtask

  task automatic send_word(input logic [DW-1:0] d, input logic last);
    bit rdy;
    int guard;
    guard        = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = last;
    do begin
      rdy = bus.in_ready;
      @(negedge clock);
      guard++;
    end while (!rdy && guard < 200);
    check_eq("word_accepted", 32'(rdy), 1);
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  // One load + compute session; expectations come from the word list, mode and step target k.
  task automatic run_txn(input bit run_mode, input int k, input int max_gap);
    int n, acc, exp_steps, falls, step_at, guard, period;
    bit ovf, exp_to, done_seen, prev;
    n         = words_q.size();
    acc       = (n < MAX_WORDS) ? n : MAX_WORDS;
    ovf       = (n > MAX_WORDS);
    exp_steps = k;
    exp_to    = 1'b0;
`ifdef TM_SEQ_STEP_LIMIT_EN
    if (k > MAX_STEPS) begin
      exp_steps = MAX_STEPS;
      exp_to    = 1'b1;
    end
`endif
    do_reset();
    tr_next.delete();
    tr_done.delete();
    tr_data.delete();
    rec_en  = 1'b1;
    bus.run = run_mode;

    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, max_gap)) @(negedge clock);
      send_word(words_q[i], (i == n - 1));
      if (i == 0) check_eq("busy_loading", 32'(bus.busy), 1);
      if (i == 0 && n > 1) begin
        period = 1;
        while (!bus.in_ready && period < 50) begin
          @(negedge clock);
          period++;
        end
        check_eq("word_period", period, 2 * HOLD + 1);
      end
    end

    if (k == 0) bus.Compute_done = 1'b1;
    falls     = 0;
    done_seen = 1'b0;
    prev      = bus.Next;
    step_at   = -1;
    guard     = 0;
    while (!bus.finished && guard < 3000) begin
      bus.step = 1'b0;
      if (done_seen && prev && !bus.Next) begin
        falls++;
        if (falls == k) bus.Compute_done = 1'b1;
        else step_at = guard + HOLD + $urandom_range(0, max_gap);
      end
      if (bus.Done) begin
        done_seen = 1'b1;
        step_at   = guard + 1 + $urandom_range(0, max_gap);
        if (!run_mode) bus.step = 1'b1;
      end
      if (!run_mode && done_seen && bus.Next) bus.step = 1'b1;
      if (!run_mode && falls < k && guard == step_at) bus.step = 1'b1;
      prev = bus.Next;
      @(negedge clock);
      guard++;
    end
    bus.step = 1'b0;
    rec_en   = 1'b0;
    check_eq("finished", 32'(bus.finished), 1);

    begin
      int starts[$];
      int lens[$];
      int dones[$];
      int overlap, nload, nstep, bad_data;
      overlap  = 0;
      nload    = 0;
      nstep    = 0;
      bad_data = 0;
      for (int i = 0; i < tr_next.size(); i++) begin
        if (tr_next[i] && (i == 0 || !tr_next[i-1])) begin
          starts.push_back(i);
          lens.push_back(0);
        end
        if (tr_next[i]) lens[lens.size()-1]++;
        if (tr_done[i]) dones.push_back(i);
        if (tr_next[i] && tr_done[i]) overlap++;
      end
      check_eq("done_count", dones.size(), 1);
      check_eq("next_done_overlap", overlap, 0);
      if (dones.size() == 1) begin
        foreach (starts[j]) begin
          if (starts[j] < dones[0]) nload++;
          else nstep++;
        end
        check_eq("load_pulses", nload, acc);
        check_eq("step_pulses", nstep, exp_steps);
        foreach (starts[j]) check_eq((j < nload) ? "load_width" : "step_width", lens[j], HOLD);
        for (int j = 0; j < nload && j < acc; j++)
          check_eq("load_data", 32'(tr_data[starts[j]]), 32'(words_q[j]));
        for (int j = nload; j + 1 < starts.size(); j++)
          check_eq("step_spacing", 32'((starts[j+1] - starts[j] - lens[j]) >= HOLD + 1), 1);
        if (run_mode && nstep > 0) check_eq("first_step_delay", starts[nload] - dones[0], 2);
        if (dones[0] > 0) check_eq("next_low_before_done", 32'(tr_next[dones[0]-1]), 0);
        if (!ovf && nload > 0) check_eq("done_latency", dones[0] - starts[nload-1], 2 * HOLD);
        for (int i = dones[0]; i < tr_data.size(); i++)
          if (tr_data[i] !== words_q[acc-1]) bad_data++;
        check_eq("compute_data_stable", bad_data, 0);
      end
    end

    check_eq("word_count", 32'(bus.word_count), acc);
    check_eq("step_count", 32'(bus.step_count), exp_steps);
    check_eq("overflow", 32'(bus.overflow), 32'(ovf));
    check_eq("timeout", 32'(bus.timeout), 32'(exp_to));
    check_eq("busy_finished", 32'(bus.busy), 0);
    check_eq("in_ready_finished", 32'(bus.in_ready), 0);

    bus.Compute_done = 1'b0;
    bus.run          = 1'b1;
    repeat (3) @(negedge clock);
    check_eq("finished_hold", 32'(bus.finished), 1);
    check_eq("finished_next", 32'(bus.Next), 0);
    check_eq("finished_steps_hold", 32'(bus.step_count), exp_steps);
  endtask

  task automatic reset_mid_step();
    int guard, falls;
    bit prev, done_seen;
    guard     = 0;
    falls     = 0;
    prev      = 1'b0;
    done_seen = 1'b0;
    do_reset();
    bus.run = 1'b1;
    send_word(4'hA, 1'b1);
    while (guard < 200) begin
      if (bus.Done) done_seen = 1'b1;
      if (done_seen && prev && !bus.Next) falls++;
      if (falls == 1 && bus.Next) break;
      prev = bus.Next;
      @(negedge clock);
      guard++;
    end
    check_eq("mid_step_next", 32'(bus.Next), 1);
    check_eq("mid_step_count", 32'(bus.step_count), 1);
    reset_n = 1'b0;
    @(negedge clock);
    check_eq("rst_mid_next", 32'(bus.Next), 0);
    check_eq("rst_mid_word_count", 32'(bus.word_count), 0);
    check_eq("rst_mid_step_count", 32'(bus.step_count), 0);
    check_eq("rst_mid_input_data", 32'(bus.input_data), 0);
    check_eq("rst_mid_busy", 32'(bus.busy), 0);
    check_eq("rst_mid_in_ready", 32'(bus.in_ready), 0);
    reset_n = 1'b1;
    @(negedge clock);
    check_eq("in_ready_after_release", 32'(bus.in_ready), 1);
  endtask

  initial begin
    bus.in_valid     = 1'b0;
    bus.in_data      = '0;
    bus.in_last      = 1'b0;
    bus.run          = 1'b0;
    bus.step         = 1'b0;
    bus.Compute_done = 1'b0;
    reset_n          = 1'b0;
    repeat (2) @(negedge clock);
    check_eq("rst_next", 32'(bus.Next), 0);
    check_eq("rst_done", 32'(bus.Done), 0);
    check_eq("rst_input_data", 32'(bus.input_data), 0);
    check_eq("rst_word_count", 32'(bus.word_count), 0);
    check_eq("rst_step_count", 32'(bus.step_count), 0);
    check_eq("rst_overflow", 32'(bus.overflow), 0);
    check_eq("rst_timeout", 32'(bus.timeout), 0);
    check_eq("rst_finished", 32'(bus.finished), 0);
    check_eq("rst_busy", 32'(bus.busy), 0);
    check_eq("rst_in_ready", 32'(bus.in_ready), 0);

    words_q = '{4'h3, 4'h1, 4'h5};
    run_txn(1'b1, 4, 0);

    words_q = '{4'h9, 4'h6};
    run_txn(1'b0, 1, 2);

    words_q = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5};
    run_txn(1'b1, 2, 1);

    reset_mid_step();

    for (int t = 0; t < 20; t++) begin
      int n;
      n = $urandom_range(1, 6);
      words_q.delete();
      for (int i = 0; i < n; i++) words_q.push_back(DW'($urandom));
      run_txn(1'($urandom_range(0, 1)), $urandom_range(0, 5), $urandom_range(0, 3));
    end

`ifdef TM_SEQ_STEP_LIMIT_EN
    words_q = '{4'h7};
    run_txn(1'b1, MAX_STEPS + 100, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, vectors %0d", n_vec);
    $fatal(1);
  end

endmodule
